beta_dmem_responder: RTL and testbench
======================================

BETA_DMEM_RESPONDER -- requirements
Module: beta_dmem_responder

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32: data bus width in bits.
REQ-002 The block SHALL have parameter AddressWidth, default 32: byte address width.
REQ-003 The block SHALL have parameter Depth, default 1024: storage size in DataWidth-bit words, power of two.
REQ-004 The block SHALL have parameter Latency, default 1, legal range 1..15: cycles from accept to response.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the only clock, rising edge; reset is asynchronous and active-low on rstn_i.
REQ-006 The block SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have read-port inputs rdata_req_i (1), rdata_addr_i (AddressWidth) and rdata_strb_i (DataWidth/8): core read request, byte address and byte-lane enables.
REQ-008 The block SHALL have read-port outputs rdata_ready_o (1), rdata_valid_o (1) and rdata_data_o (DataWidth): request accepted, response pulse and read data.
REQ-009 The block SHALL have write-port inputs wdata_req_i (1), wdata_addr_i (AddressWidth), wdata_data_i (DataWidth) and wdata_strb_i (DataWidth/8).
REQ-010 The block SHALL have write-port outputs wdata_ready_o (1) and wdata_valid_o (1): request accepted and write-complete pulse.

Function
REQ-011 Each port SHALL run an independent FSM with states IDLE, WAIT and RESP, encoded as a shared state enum.
REQ-012 Each port's ready SHALL be high only in IDLE, decoded from the state register, and SHALL never be combinationally derived from req.
REQ-013 A request SHALL be accepted on the rising edge where req and ready are both high; the port then leaves IDLE.
REQ-014 On accept, the FSM SHALL go to WAIT when Latency>1, loading a down-counter with Latency-1, and SHALL go directly to RESP when Latency==1.
REQ-015 WAIT SHALL decrement the counter every cycle and go to RESP when the counter is 1.
REQ-016 valid SHALL be high exactly one cycle, in RESP, Latency cycles after the accept edge; RESP SHALL always return to IDLE.
REQ-017 The port SHALL hold one outstanding request; the minimum accept-to-accept interval is Latency+1 cycles.
REQ-018 The word index SHALL be addr[$clog2(Depth)+1:2]; addr[1:0] SHALL be ignored, and upper bits SHALL be ignored so addresses wrap modulo Depth words.
REQ-019 Read data SHALL be sampled from storage at the accept edge, registered, and held on rdata_data_o until the next read response.
REQ-020 Byte lanes whose rdata_strb bit is 0 SHALL read as 0x00.
REQ-021 Writes SHALL commit at the accept edge, updating only the byte lanes whose wdata_strb bit is 1.
REQ-022 A request with an all-zero strobe SHALL still be accepted and answered, and SHALL leave storage unchanged.
REQ-023 For a read and a write accepted on the same edge to the same word, the read SHALL return the pre-write (old) data.
REQ-024 A read accepted on any edge after a write's accept edge SHALL see the written data, even if wdata_valid_o has not yet pulsed.
REQ-025 req deasserted during WAIT or RESP SHALL have no effect; the response SHALL still be issued.

Reset
REQ-026 While rstn_i is low, both FSMs SHALL be in IDLE, counters 0, rdata_valid_o=0, wdata_valid_o=0 and rdata_data_o=0.
REQ-027 rdata_ready_o and wdata_ready_o SHALL be 0 while rstn_i is low and SHALL be 1 from the first clock edge after reset release.
REQ-028 Reset asserted mid-transaction SHALL drop the pending response without emitting valid.
REQ-029 A write already accepted before reset SHALL remain committed.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 The state enum mem_resp_state_t {IDLE, WAIT, RESP} and the constant MEM_MAX_LATENCY=15 SHALL be added to beta_pkg.
REQ-032 The FSM and latency counter SHALL be a sub-module, beta_mem_port_fsm (ports: clk_i, rstn_i, req_i, ready_o, accept_o, valid_o), instantiated once per port.
REQ-033 The storage array and the strobe masking SHALL live in beta_dmem_responder.

Verification
REQ-034 Latency=1: write 0xDEADBEEF to 0x10 with strb 0xF, then read 0x10 with strb 0xF -> wdata_valid_o one cycle after accept, rdata_data_o=0xDEADBEEF one cycle after read accept, ready low for exactly 1 cycle per transaction.
REQ-035 Latency=4: read with req held high continuously -> accepts every 5 cycles, valid 4 cycles after each accept.
REQ-036 Word 0x20 holds 0x11223344; write 0xAABBCCDD with strb 0x6, then read with strb 0xF -> 0x11BBCC44; read with strb 0x3 -> 0x0000CC44.
REQ-037 Word 0x40 holds 0x0; write 0x55 and read same word on the same edge -> read returns 0x0, next read returns 0x55; and with Depth=1024, address 0x1004 aliases 0x0004.
REQ-038 Latency=8: assert rstn_i low 3 cycles after a read accept -> no rdata_valid_o pulse, ready=1 on the first edge after release, and the next request is served normally.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta core memory-side blocks.
package beta_pkg;

  localparam int MEM_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_t;

endpackage

// File: rtl/beta_mem_port_fsm.sv
// Single-outstanding request/response sequencer with a fixed accept-to-valid latency.
// ready is a pure state decode; valid is a one-cycle pulse Latency cycles after accept.
module beta_mem_port_fsm
  import beta_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic req_i,
  output logic ready_o,
  output logic accept_o,
  output logic valid_o
);

  localparam int CntW = $clog2(MEM_MAX_LATENCY + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(Latency - 1);

  mem_resp_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed_q;

  // armed_q keeps ready low during reset, even though the state register sits in IDLE
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  assign ready_o  = armed_q && (state_q == IDLE);
  assign accept_o = req_i && ready_o;
  assign valid_o  = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_o) begin
          if (Latency > 1) begin
            state_d = WAIT;
            cnt_d   = LoadVal;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/beta_dmem_responder.sv
// Data-memory responder: word storage with byte strobes behind independent read and write ports.
// Reads sample at the accept edge; writes commit at the accept edge; both respond after Latency cycles.
module beta_dmem_responder
  import beta_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int Depth        = 1024,
  parameter int Latency      = 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    rdata_req_i,
  input  logic [AddressWidth-1:0] rdata_addr_i,
  input  logic [DataWidth/8-1:0]  rdata_strb_i,
  output logic                    rdata_ready_o,
  output logic                    rdata_valid_o,
  output logic [DataWidth-1:0]    rdata_data_o,
  input  logic                    wdata_req_i,
  input  logic [AddressWidth-1:0] wdata_addr_i,
  input  logic [DataWidth-1:0]    wdata_data_i,
  input  logic [DataWidth/8-1:0]  wdata_strb_i,
  output logic                    wdata_ready_o,
  output logic                    wdata_valid_o
);

  localparam int StrbW = DataWidth / 8;
  localparam int IdxW  = $clog2(Depth);

  logic                 rd_accept, wr_accept;
  logic [IdxW-1:0]      rd_idx, wr_idx;
  logic [DataWidth-1:0] rd_mask;
  logic [DataWidth-1:0] rd_pend_q, rd_hold_q;
  logic [DataWidth-1:0] mem [Depth];
  logic                 unused_addr_bits;

  beta_mem_port_fsm #(.Latency(Latency)) u_rd_fsm (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (rdata_req_i),
    .ready_o  (rdata_ready_o),
    .accept_o (rd_accept),
    .valid_o  (rdata_valid_o)
  );

  beta_mem_port_fsm #(.Latency(Latency)) u_wr_fsm (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (wdata_req_i),
    .ready_o  (wdata_ready_o),
    .accept_o (wr_accept),
    .valid_o  (wdata_valid_o)
  );

  // Byte offset and upper address bits are dropped, so addresses wrap modulo Depth words
  assign rd_idx = rdata_addr_i[IdxW+1:2];
  assign wr_idx = wdata_addr_i[IdxW+1:2];
  assign unused_addr_bits = ^{rdata_addr_i[1:0], rdata_addr_i[AddressWidth-1:IdxW+2],
                              wdata_addr_i[1:0], wdata_addr_i[AddressWidth-1:IdxW+2]};

  for (genvar b = 0; b < StrbW; b++) begin : g_rd_mask
    assign rd_mask[b*8 +: 8] = {8{rdata_strb_i[b]}};
  end

  // Storage is never reset; a same-edge read sees the old word because this update is non-blocking
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wdata_strb_i[b]) mem[wr_idx][b*8 +: 8] <= wdata_data_i[b*8 +: 8];
      end
    end
  end

  // rd_pend_q captures at accept; rd_hold_q keeps the last delivered word between responses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_pend_q <= '0;
      rd_hold_q <= '0;
    end else begin
      if (rd_accept)     rd_pend_q <= mem[rd_idx] & rd_mask;
      if (rdata_valid_o) rd_hold_q <= rd_pend_q;
    end
  end

  assign rdata_data_o = rdata_valid_o ? rd_pend_q : rd_hold_q;

endmodule

// File: tb/tb_beta_dmem_responder.sv
// Directed bench for beta_dmem_responder at Latency 1, 4 and 8.
module tb_beta_dmem_responder;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  logic        r1_req, r1_rdy, r1_vld, w1_req, w1_rdy, w1_vld;
  logic [31:0] r1_addr, r1_dat, w1_addr, w1_dat;
  logic [3:0]  r1_strb, w1_strb;
  logic        r4_req, r4_rdy, r4_vld, w4_req, w4_rdy, w4_vld;
  logic [31:0] r4_addr, r4_dat, w4_addr, w4_dat;
  logic [3:0]  r4_strb, w4_strb;
  logic        r8_req, r8_rdy, r8_vld, w8_req, w8_rdy, w8_vld;
  logic [31:0] r8_addr, r8_dat, w8_addr, w8_dat;
  logic [3:0]  r8_strb, w8_strb;

  beta_dmem_responder #(.Latency(1)) u_l1 (
    .clk_i(clk), .rstn_i(rstn),
    .rdata_req_i(r1_req), .rdata_addr_i(r1_addr), .rdata_strb_i(r1_strb),
    .rdata_ready_o(r1_rdy), .rdata_valid_o(r1_vld), .rdata_data_o(r1_dat),
    .wdata_req_i(w1_req), .wdata_addr_i(w1_addr), .wdata_data_i(w1_dat), .wdata_strb_i(w1_strb),
    .wdata_ready_o(w1_rdy), .wdata_valid_o(w1_vld)
  );

  beta_dmem_responder #(.Latency(4)) u_l4 (
    .clk_i(clk), .rstn_i(rstn),
    .rdata_req_i(r4_req), .rdata_addr_i(r4_addr), .rdata_strb_i(r4_strb),
    .rdata_ready_o(r4_rdy), .rdata_valid_o(r4_vld), .rdata_data_o(r4_dat),
    .wdata_req_i(w4_req), .wdata_addr_i(w4_addr), .wdata_data_i(w4_dat), .wdata_strb_i(w4_strb),
    .wdata_ready_o(w4_rdy), .wdata_valid_o(w4_vld)
  );

  beta_dmem_responder #(.Latency(8)) u_l8 (
    .clk_i(clk), .rstn_i(rstn),
    .rdata_req_i(r8_req), .rdata_addr_i(r8_addr), .rdata_strb_i(r8_strb),
    .rdata_ready_o(r8_rdy), .rdata_valid_o(r8_vld), .rdata_data_o(r8_dat),
    .wdata_req_i(w8_req), .wdata_addr_i(w8_addr), .wdata_data_i(w8_dat), .wdata_strb_i(w8_strb),
    .wdata_ready_o(w8_rdy), .wdata_valid_o(w8_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    w1_req = 1'b1; w1_addr = a; w1_dat = d; w1_strb = s;
    tick();
    check("wr1_vld_pulse", {31'd0, w1_vld}, 32'd1);
    check("wr1_rdy_low", {31'd0, w1_rdy}, 32'd0);
    w1_req = 1'b0;
    tick();
    check("wr1_back_idle", {30'd0, w1_rdy, w1_vld}, 32'd2);
  endtask

  task automatic rd1(input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp);
    r1_req = 1'b1; r1_addr = a; r1_strb = s;
    tick();
    check("rd1_vld_pulse", {31'd0, r1_vld}, 32'd1);
    check("rd1_data", r1_dat, exp);
    r1_req = 1'b0;
    tick();
    check("rd1_back_idle", {30'd0, r1_rdy, r1_vld}, 32'd2);
    check("rd1_data_held", r1_dat, exp);
  endtask

  task automatic rd8(input logic [31:0] a, input logic [31:0] exp);
    r8_req = 1'b1; r8_addr = a; r8_strb = 4'hF;
    tick();
    r8_req = 1'b0;
    repeat (6) tick();
    check("rd8_no_early_vld", {31'd0, r8_vld}, 32'd0);
    tick();
    check("rd8_vld_at_lat", {31'd0, r8_vld}, 32'd1);
    check("rd8_data", r8_dat, exp);
    tick();
  endtask

  initial begin
    logic saw_vld;
    n_tests = 0; n_fail = 0;
    rstn = 1'b0;
    r1_req = 0; r1_addr = 0; r1_strb = 0; w1_req = 0; w1_addr = 0; w1_dat = 0; w1_strb = 0;
    r4_req = 0; r4_addr = 0; r4_strb = 0; w4_req = 0; w4_addr = 0; w4_dat = 0; w4_strb = 0;
    r8_req = 0; r8_addr = 0; r8_strb = 0; w8_req = 0; w8_addr = 0; w8_dat = 0; w8_strb = 0;

    repeat (2) tick();
    check("rst_rdy_l1", {30'd0, r1_rdy, w1_rdy}, 32'd0);
    check("rst_vld_l1", {30'd0, r1_vld, w1_vld}, 32'd0);
    check("rst_data_l1", r1_dat, 32'd0);
    check("rst_rdy_l8", {30'd0, r8_rdy, w8_rdy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rdy_before_first_edge", {31'd0, r1_rdy}, 32'd0);
    tick();
    check("rdy_after_release", {26'd0, r1_rdy, w1_rdy, r4_rdy, w4_rdy, r8_rdy, w8_rdy}, 32'h3F);

    // Latency 1: basic write/read, strobes, zero strobe, same-edge ordering, aliasing
    wr1(32'h10, 32'hDEADBEEF, 4'hF);
    rd1(32'h10, 4'hF, 32'hDEADBEEF);
    wr1(32'h20, 32'h11223344, 4'hF);
    wr1(32'h20, 32'hAABBCCDD, 4'h6);
    rd1(32'h20, 4'hF, 32'h11BBCC44);
    rd1(32'h20, 4'h3, 32'h0000CC44);
    wr1(32'h20, 32'hFFFFFFFF, 4'h0);
    rd1(32'h20, 4'hF, 32'h11BBCC44);
    rd1(32'h20, 4'h0, 32'h00000000);
    wr1(32'h40, 32'h0, 4'hF);
    w1_req = 1'b1; w1_addr = 32'h40; w1_dat = 32'h55; w1_strb = 4'hF;
    r1_req = 1'b1; r1_addr = 32'h40; r1_strb = 4'hF;
    tick();
    check("same_edge_old_data", r1_dat, 32'h0);
    check("same_edge_both_vld", {30'd0, r1_vld, w1_vld}, 32'd3);
    w1_req = 1'b0; r1_req = 1'b0;
    tick();
    rd1(32'h40, 4'hF, 32'h55);
    wr1(32'h1004, 32'hCAFEF00D, 4'hF);
    rd1(32'h0004, 4'hF, 32'hCAFEF00D);
    rd1(32'h0007, 4'hF, 32'hCAFEF00D);

    // Latency 4: write then continuous read request
    w4_req = 1'b1; w4_addr = 32'h8; w4_dat = 32'h12345678; w4_strb = 4'hF;
    tick();
    w4_req = 1'b0;
    check("l4_wr_wait", {30'd0, w4_rdy, w4_vld}, 32'd0);
    repeat (2) tick();
    check("l4_wr_no_early_vld", {31'd0, w4_vld}, 32'd0);
    tick();
    check("l4_wr_vld", {31'd0, w4_vld}, 32'd1);
    tick();
    r4_req = 1'b1; r4_addr = 32'h8; r4_strb = 4'hF;
    for (int c = 0; c < 20; c++) begin
      check("l4_accept_slot", {31'd0, r4_rdy}, {31'd0, (c % 5) == 0});
      check("l4_vld_slot", {31'd0, r4_vld}, {31'd0, (c % 5) == 4});
      if ((c % 5) == 4) check("l4_data", r4_dat, 32'h12345678);
      tick();
    end
    r4_req = 1'b0;
    tick();

    // Latency 8: read one edge after a write sees the new data before the write completes
    w8_req = 1'b1; w8_addr = 32'h30; w8_dat = 32'hA5A50001; w8_strb = 4'hF;
    tick();
    w8_req = 1'b0;
    r8_req = 1'b1; r8_addr = 32'h30; r8_strb = 4'hF;
    tick();
    r8_req = 1'b0;
    check("l8_wr_not_done_yet", {31'd0, w8_vld}, 32'd0);
    repeat (6) tick();
    check("l8_wr_vld", {30'd0, w8_vld, r8_vld}, 32'd2);
    tick();
    check("l8_rd_vld", {30'd0, w8_vld, r8_vld}, 32'd1);
    check("l8_rd_after_wr", r8_dat, 32'hA5A50001);
    tick();

    // Latency 8: reset mid-transaction drops the response but keeps the accepted write
    r8_req = 1'b1; r8_addr = 32'h30; r8_strb = 4'hF;
    w8_req = 1'b1; w8_addr = 32'h34; w8_dat = 32'h0BADCAFE; w8_strb = 4'hF;
    tick();
    r8_req = 1'b0; w8_req = 1'b0;
    saw_vld = 1'b0;
    repeat (3) begin
      tick();
      saw_vld = saw_vld | r8_vld | w8_vld;
    end
    rstn = 1'b0;
    #1;
    check("mid_rst_rdy", {30'd0, r8_rdy, w8_rdy}, 32'd0);
    check("mid_rst_data", r8_dat, 32'd0);
    repeat (3) begin
      tick();
      saw_vld = saw_vld | r8_vld | w8_vld;
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post_rst_rdy", {30'd0, r8_rdy, w8_rdy}, 32'd3);
    repeat (10) begin
      saw_vld = saw_vld | r8_vld | w8_vld;
      tick();
    end
    check("no_vld_after_rst", {31'd0, saw_vld}, 32'd0);
    rd8(32'h34, 32'h0BADCAFE);
    rd8(32'h30, 32'hA5A50001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
